// File: rtl/fifo_gc_selftest.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_gc_selftest
//  Description : Self-exercising 2^AW-entry FIFO with binary + Gray-coded
//                pointers. An internal counter writes on every edge while
//                not full. Reads happen on every other edge while not empty.
//                dataOut carries the most recently read entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_gc_selftest #(
  parameter int WIDTH = 3,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rstN,
  output logic [WIDTH-1:0] dataOut,
  output logic             full,
  output logic             empty
);

  localparam int c_DEPTH = 1 << AW;

  // Storage is intentionally not reset. Only entries written since the last
  // reset are ever addressed by the read pointer.
  logic [WIDTH-1:0] r_mem [c_DEPTH];

  logic [AW:0]      r_wbin;
  logic [AW:0]      r_wgray;
  logic [AW:0]      r_rbin;
  logic [AW:0]      r_rgray;
  logic [WIDTH-1:0] r_wdata;
  logic             r_readPhase;
  logic [WIDTH-1:0] r_dataOut;

  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;
  logic [AW:0]      w_wbin_nxt;
  logic [AW:0]      w_rbin_nxt;
  logic [AW:0]      w_wgray_nxt;
  logic [AW:0]      w_rgray_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_do_write;
  logic             w_do_read;

  // Addresses, next pointer values and flags derived from pre-edge pointer state.
  always_comb begin
    w_waddr     = r_wbin[AW-1:0];
    w_raddr     = r_rbin[AW-1:0];
    w_wbin_nxt  = r_wbin + 1'b1;
    w_rbin_nxt  = r_rbin + 1'b1;
    w_wgray_nxt = w_wbin_nxt ^ (w_wbin_nxt >> 1);
    w_rgray_nxt = w_rbin_nxt ^ (w_rbin_nxt >> 1);
    // Equal Gray pointers mean no entries are held. Differing only in the
    // two MSBs means the write side is exactly one lap ahead.
    w_empty     = (r_rgray == r_wgray);
    w_full      = (r_wgray == {~r_rgray[AW:AW-1], r_rgray[AW-2:0]});
    w_do_write  = ~w_full;
    w_do_read   = r_readPhase & ~w_empty;
  end

  // The storage array captures the write-data counter on every accepted write.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[w_waddr] <= r_wdata;
    end
  end

  // Write pointer pair and the write-data counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_wdata <= '0;
    end else if (w_do_write) begin
      r_wbin  <= w_wbin_nxt;
      r_wgray <= w_wgray_nxt;
      r_wdata <= r_wdata + 1'b1;
    end
  end

  // Read pointer pair and the registered output word.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rbin    <= '0;
      r_rgray   <= '0;
      r_dataOut <= '0;
    end else if (w_do_read) begin
      r_rbin    <= w_rbin_nxt;
      r_rgray   <= w_rgray_nxt;
      r_dataOut <= r_mem[w_raddr];
    end
  end

  // The read-phase toggle limits reads to every other edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_readPhase <= 1'b0;
    end else begin
      r_readPhase <= ~r_readPhase;
    end
  end

  assign dataOut = r_dataOut;
  assign full    = w_full;
  assign empty   = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fifo_gc_selftest.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_gc_selftest
//  Description : Self-checking bench for fifo_gc_selftest. It checks a table
//                of known post-reset values. It then checks long runs and
//                random mid-run resets against a queue-based FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_gc_selftest;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] dataOut;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue holds the stored words, oldest first.
  int q[$];
  int m_wcnt;
  bit m_rph;
  int m_dout;

  typedef struct {
    int n;     // edges since reset release
    int dout;
    bit emp;
    bit ful;
  } vec_t;

  vec_t tbl[13];

  fifo_gc_selftest #(.WIDTH(3), .AW(3)) dut (
    .clk     (clk),
    .rstN    (rstN),
    .dataOut (dataOut),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wcnt = 0;
    m_rph  = 1'b0;
    m_dout = 0;
  endtask

  // Apply one clock edge to the model. Both decisions use the pre-edge occupancy.
  task automatic model_edge();
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    if (m_rph && !was_empty) m_dout = q.pop_front();
    if (!was_full) begin
      q.push_back(m_wcnt);
      m_wcnt = (m_wcnt + 1) % 8;
    end
    m_rph = ~m_rph;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dataOut"}, int'(dataOut), m_dout);
    chk({tag, ".empty"}, int'(empty), int'(q.size() == 0));
    chk({tag, ".full"}, int'(full), int'(q.size() == 8));
    chk({tag, ".not_both"}, int'(full && empty), 0);
  endtask

  task automatic edge_step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".dataOut"}, int'(dataOut), 0);
    chk({tag, ".empty"}, int'(empty), 1);
    chk({tag, ".full"}, int'(full), 0);
  endtask

  // Reset is asserted at a clock low phase. It is held across a running clock edge and released at a negedge.
  task automatic apply_reset();
    @(negedge clk);
    rstN = 1'b0;
    model_reset();
    #1;
    check_reset_state("rst_hold");
    @(posedge clk);
    #1;
    check_reset_state("rst_clk");
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    int cur;
    int nrun;

    // Expected values after n edges following reset release.
    tbl[0]  = '{0,  0, 1'b1, 1'b0};
    tbl[1]  = '{1,  0, 1'b0, 1'b0};
    tbl[2]  = '{2,  0, 1'b0, 1'b0};
    tbl[3]  = '{3,  0, 1'b0, 1'b0};
    tbl[4]  = '{4,  1, 1'b0, 1'b0};
    tbl[5]  = '{5,  1, 1'b0, 1'b0};
    tbl[6]  = '{6,  2, 1'b0, 1'b0};
    tbl[7]  = '{14, 6, 1'b0, 1'b0};
    tbl[8]  = '{15, 6, 1'b0, 1'b1};
    tbl[9]  = '{16, 7, 1'b0, 1'b0};
    tbl[10] = '{17, 7, 1'b0, 1'b1};
    tbl[11] = '{18, 0, 1'b0, 1'b0};
    tbl[12] = '{20, 1, 1'b0, 1'b0};

    rstN = 1'b0;
    repeat (2) @(posedge clk);
    apply_reset();

    // Table-driven check of the start-up sequence and the first fill.
    cur = 0;
    for (int i = 0; i < 13; i++) begin
      while (cur < tbl[i].n) begin
        @(posedge clk);
        #1;
        cur++;
      end
      chk($sformatf("tbl[%0d].dataOut", tbl[i].n), int'(dataOut), tbl[i].dout);
      chk($sformatf("tbl[%0d].empty", tbl[i].n), int'(empty), int'(tbl[i].emp));
      chk($sformatf("tbl[%0d].full", tbl[i].n), int'(full), int'(tbl[i].ful));
    end

    // Long run across the data-counter and pointer wraps, checked against the model.
    apply_reset();
    for (int i = 0; i < 40; i++) edge_step("run40");

    // Randomised run lengths, each ended by an asynchronous reset between edges.
    for (int it = 0; it < 8; it++) begin
      nrun = $urandom_range(1, 45);
      for (int i = 0; i < nrun; i++) edge_step("rand");
      #($urandom_range(1, 3));
      rstN = 1'b0;
      model_reset();
      #1;
      check_reset_state("async_rst");
      @(posedge clk);
      #1;
      check_reset_state("async_rst_clk");
      @(negedge clk);
      rstN = 1'b1;
      // After release, the output sequence starts again at 0, 1, 2.
      for (int i = 0; i < 6; i++) edge_step("restart");
      chk("restart.seq", int'(dataOut), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
